// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the 5-stage MIPS core.
//
// Resolves load-use hazards (one bubble), flushes IF/ID on taken branches and
// jumps, and holds the front end while a mult/div runs in the multi-cycle
// unit (start pulse, wait for done, forced release on timeout).
//
// Optional build macro: HAZARD_PERF_CNT_EN adds lu_stall_cnt / mc_stall_cnt.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   MemRead_ex          EX instruction is a load
//   RtAddr_ex           load destination in EX
//   RsAddr_id/RtAddr_id source registers of ID instruction
//   UseRs_id/UseRt_id   ID instruction actually reads rs/rt
//   BranchTaken_id      branch resolved taken in ID
//   Jump_id             jump in ID
//   McOp_id             ID instruction is mult/div
//   mc_done             multi-cycle unit finished (1-cycle pulse)
//   PCWrite             PC update enable
//   IFIDWrite           IF/ID load enable
//   IFIDFlush           IF/ID clear to NOP
//   IDEXBubble          ID/EX stall input (zeroes the ID/EX payload)
//   mc_start            registered 1-cycle start pulse to multi-cycle unit
//   mc_busy             high while waiting on the multi-cycle unit
//   mc_timeout          sticky timeout flag, cleared only by reset
//   lu_stall_cnt        (HAZARD_PERF_CNT_EN) load-use stall cycles
//   mc_stall_cnt        (HAZARD_PERF_CNT_EN) mult/div wait cycles w/o release
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_ex,
  input  logic [4:0]  RtAddr_ex,
  input  logic [4:0]  RsAddr_id,
  input  logic [4:0]  RtAddr_id,
  input  logic        UseRs_id,
  input  logic        UseRt_id,
  input  logic        BranchTaken_id,
  input  logic        Jump_id,
  input  logic        McOp_id,
  input  logic        mc_done,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic        mc_start,
  output logic        mc_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] mc_stall_cnt,
`endif
  output logic        mc_timeout
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             lu_hazard;
  logic             start_nxt;
  logic             to_set;
  logic             release_mc;

  // $0 is never a real dependency, so a load to $0 never stalls.
  assign lu_hazard = MemRead_ex && (RtAddr_ex != 5'd0) &&
                     ((UseRs_id && (RtAddr_ex == RsAddr_id)) ||
                      (UseRt_id && (RtAddr_ex == RtAddr_id)));

  // Done wins over timeout when both land in the same cycle.
  assign release_mc = (state == MC_WAIT) && (mc_done || (wait_cnt == CNT_LAST));

  always_comb begin
    state_nxt  = state;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    mc_busy    = 1'b0;
    start_nxt  = 1'b0;
    to_set     = 1'b0;
    case (state)
      RUN: begin
        if (lu_hazard) begin
          // Branch/McOp behind the hazard simply re-presents next cycle.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end else if (BranchTaken_id || Jump_id) begin
          IFIDFlush  = 1'b1;
        end else if (McOp_id) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          start_nxt  = 1'b1;
          state_nxt  = MC_WAIT;
        end
      end
      MC_WAIT: begin
        mc_busy = 1'b1;
        if (release_mc) begin
          // Release: the mult/div enters EX this cycle.
          to_set    = !mc_done;
          state_nxt = RUN;
        end else begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    // Hold the front end and drain the pipe to NOPs while in reset.
    if (reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      mc_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      mc_timeout <= 1'b0;
      mc_start   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= (state == MC_WAIT && !release_mc) ? wait_cnt + 1'b1 : '0;
      mc_timeout <= mc_timeout | to_set;
      mc_start   <= start_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_stall_cnt <= '0;
      mc_stall_cnt <= '0;
    end else begin
      if (state == RUN && lu_hazard)
        lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (state == MC_WAIT && !release_mc)
        mc_stall_cnt <= mc_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl. The driver applies one vector per
// cycle and queues the hand-computed response; the monitor pops and compares
// on the falling edge. Response bits: {PCWrite, IFIDWrite, IFIDFlush,
// IDEXBubble, mc_start, mc_busy, mc_timeout}. Built with MC_TIMEOUT=8.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemRead_ex;
  logic [4:0] RtAddr_ex, RsAddr_id, RtAddr_id;
  logic       UseRs_id, UseRt_id, BranchTaken_id, Jump_id, McOp_id, mc_done;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, mc_start, mc_busy, mc_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, mc_stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead_ex(MemRead_ex), .RtAddr_ex(RtAddr_ex),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
    .UseRs_id(UseRs_id), .UseRt_id(UseRt_id),
    .BranchTaken_id(BranchTaken_id), .Jump_id(Jump_id),
    .McOp_id(McOp_id), .mc_done(mc_done),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .mc_start(mc_start), .mc_busy(mc_busy),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt), .mc_stall_cnt(mc_stall_cnt),
`endif
    .mc_timeout(mc_timeout)
  );

  typedef struct {
    logic [6:0]  v;
    logic        chk_cnt;
    logic [31:0] lu;
    logic [31:0] mc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Response shorthands
  localparam logic [6:0] NRM  = 7'b1100000; // normal flow
  localparam logic [6:0] STL  = 7'b0001000; // hold + bubble
  localparam logic [6:0] FLS  = 7'b1110000; // branch/jump flush
  localparam logic [6:0] WST  = 7'b0001110; // first wait cycle (start pulse)
  localparam logic [6:0] WT   = 7'b0001010; // waiting
  localparam logic [6:0] REL  = 7'b1100010; // release
  localparam logic [6:0] RST  = 7'b0011000; // in reset

  task automatic cyc(input logic rst, input logic mr, input logic [4:0] rtex,
                     input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic br, input logic j, input logic mc,
                     input logic done, input logic [6:0] e, input string nm,
                     input logic cc = 1'b0, input logic [31:0] elu = 0,
                     input logic [31:0] emc = 0);
    exp_t x;
    reset = rst; MemRead_ex = mr; RtAddr_ex = rtex;
    RsAddr_id = rs; UseRs_id = urs; RtAddr_id = rt; UseRt_id = urt;
    BranchTaken_id = br; Jump_id = j; McOp_id = mc; mc_done = done;
    x.v = e; x.chk_cnt = cc; x.lu = elu; x.mc = emc; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk); #1;
  endtask

  // Monitor: compare whatever the DUT presents against the queued response.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      logic [6:0] act;
      x = exp_q.pop_front();
      act = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, mc_start, mc_busy, mc_timeout};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", x.name, act, x.v);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (x.chk_cnt) begin
        checks++;
        if (lu_stall_cnt !== x.lu || mc_stall_cnt !== x.mc) begin
          errors++;
          $display("FAIL %s_cnt: got lu=%0d mc=%0d expected lu=%0d mc=%0d",
                   x.name, lu_stall_cnt, mc_stall_cnt, x.lu, x.mc);
        end
      end
`endif
    end
  end

  initial begin
    reset = 1'b1; MemRead_ex = 0; RtAddr_ex = 0; RsAddr_id = 0; RtAddr_id = 0;
    UseRs_id = 0; UseRt_id = 0; BranchTaken_id = 0; Jump_id = 0; McOp_id = 0;
    mc_done = 0;
    repeat (2) @(posedge clk);
    #1;
    //  rst mr rtex rs urs rt urt br j mc dn  expect
    cyc(1, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, RST, "reset", 1'b1, 0, 0);
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, NRM, "idle");
    cyc(0, 1, 2,   2, 1,  0, 0,  0, 0, 0, 0, STL, "lu_rs");
    cyc(0, 0, 2,   2, 1,  0, 0,  0, 0, 0, 0, NRM, "lu_after");
    cyc(0, 1, 0,   0, 1,  0, 0,  0, 0, 0, 0, NRM, "lu_r0");
    cyc(0, 1, 2,   2, 0,  0, 0,  0, 0, 0, 0, NRM, "lu_nouse");
    cyc(0, 1, 5,   0, 0,  5, 1,  0, 0, 0, 0, STL, "lu_rt");
    cyc(0, 1, 3,   3, 1,  0, 0,  1, 0, 0, 0, STL, "lu_br_stall");
    cyc(0, 0, 3,   3, 1,  0, 0,  1, 0, 0, 0, FLS, "lu_br_flush");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 1, 0, 0, FLS, "jump");
    // mult with done 5 cycles after start
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, STL, "mc_issue");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WST, "mc_w0");
    for (int i = 1; i <= 4; i++)
      cyc(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 0, WT,  "mc_wait");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 1, REL, "mc_release");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 1, NRM, "done_in_run");
    // timeout: no done, release on 8th wait cycle
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, STL, "to_issue");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WST, "to_w0");
    for (int i = 1; i <= 6; i++)
      cyc(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 0, WT,  "to_wait");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, REL, "to_release");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, NRM | 7'b1, "to_sticky");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, STL | 7'b1, "to_next_issue");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WST | 7'b1, "to_next_w0");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 1, REL | 7'b1, "to_next_rel");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, NRM | 7'b1, "to_next_run");
    // reset in the 3rd wait cycle
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, STL | 7'b1, "rs_issue");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WST | 7'b1, "rs_w0");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WT  | 7'b1, "rs_w1");
    cyc(1, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, RST | 7'b1, "rs_in_reset");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, NRM, "rs_after", 1'b1, 0, 0);
    // done and timeout in the same cycle: no timeout flag
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, STL, "dt_issue");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WST, "dt_w0");
    for (int i = 1; i <= 6; i++)
      cyc(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 0, WT,  "dt_wait");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 1, REL, "dt_release");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, NRM, "dt_no_flag", 1'b1, 0, 7);
    // McOp deferred behind a load-use stall
    cyc(0, 1, 4,   4, 1,  0, 0,  0, 0, 1, 0, STL, "lumc_stall");
    cyc(0, 0, 4,   4, 1,  0, 0,  0, 0, 1, 0, STL, "lumc_issue", 1'b1, 1, 7);
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, WST, "lumc_w0");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 1, REL, "lumc_rel");
    // branch beats McOp; no start must follow
    cyc(0, 0, 0,   0, 0,  0, 0,  1, 0, 1, 0, FLS, "br_over_mc");
    cyc(0, 0, 0,   0, 0,  0, 0,  0, 0, 0, 0, NRM, "br_over_mc_next");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
